// File: rtl/vector_mac_engine.sv
// vector_mac_engine: multi-lane multiply-accumulate engine.
// Accepts one full-vector command per handshake and processes lanes_p elements
// per cycle in one of four modes: DOT, DOT_ACC, VMAC (a*b+c) and AXPY (s*a+b).
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   op_i                  mode: 00 DOT, 01 DOT_ACC, 10 VMAC, 11 AXPY
//   a_i, b_i, c_i         operand vectors, element i at [i*vdw_p +: vdw_p]
//   scalar_i              AXPY scalar
//   v_i / ready_o         command handshake
//   r_data_o              elementwise result (VMAC/AXPY)
//   acc_o                 accumulator (DOT/DOT_ACC)
//   v_o / yumi_i          result handshake
module vector_mac_engine #(
    parameter int unsigned vlen_p      = 4,
    parameter int unsigned vdw_p       = 4,
    parameter int unsigned lanes_p     = 2,
    parameter int unsigned acc_width_p = 2 * vdw_p + ((vlen_p > 1) ? $clog2(vlen_p) : 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [1:0]                op_i,
    input  logic [vlen_p*vdw_p-1:0]   a_i,
    input  logic [vlen_p*vdw_p-1:0]   b_i,
    input  logic [vlen_p*vdw_p-1:0]   c_i,
    input  logic [vdw_p-1:0]          scalar_i,
    input  logic                      v_i,
    output logic                      ready_o,
    output logic [vlen_p*vdw_p-1:0]   r_data_o,
    output logic [acc_width_p-1:0]    acc_o,
    output logic                      v_o,
    input  logic                      yumi_i
);

    localparam int unsigned vec_w_lp  = vlen_p * vdw_p;
    localparam int unsigned prod_w_lp = 2 * vdw_p;
    localparam int unsigned chunks_lp = vlen_p / lanes_p;
    localparam int unsigned cnt_w_lp  = (chunks_lp > 1) ? $clog2(chunks_lp) : 1;
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(chunks_lp - 1);

    localparam logic [1:0] op_dot  = 2'b00;
    localparam logic [1:0] op_axpy = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_n;

    logic [1:0]            op_q;
    logic [vec_w_lp-1:0]   a_q, b_q, c_q;
    logic [vdw_p-1:0]      s_q;
    logic [cnt_w_lp-1:0]   cnt_q;
    logic                  accept;

    logic [vdw_p-1:0]      a_el [lanes_p];
    logic [vdw_p-1:0]      b_el [lanes_p];
    logic [vdw_p-1:0]      c_el [lanes_p];
    logic [prod_w_lp-1:0]  prod [lanes_p];
    logic [acc_width_p-1:0] chunk_sum;
    logic [vec_w_lp-1:0]   r_n;

    assign accept = (state_q == IDLE) && v_i;

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (v_i) state_n = BUSY;
            BUSY:    if (cnt_q == last_cnt_lp) state_n = DONE;
            DONE:    if (yumi_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ready_o <= 1'b1;
            v_o     <= 1'b0;
        end else begin
            ready_o <= (state_n == IDLE);
            v_o     <= (state_n == DONE);
        end
    end

    // Lane datapath for the current chunk
    always_comb begin
        chunk_sum = '0;
        r_n       = r_data_o;
        for (int l = 0; l < lanes_p; l++) begin
            a_el[l] = a_q[(32'(cnt_q) * lanes_p + 32'(l)) * vdw_p +: vdw_p];
            b_el[l] = b_q[(32'(cnt_q) * lanes_p + 32'(l)) * vdw_p +: vdw_p];
            c_el[l] = c_q[(32'(cnt_q) * lanes_p + 32'(l)) * vdw_p +: vdw_p];
            prod[l] = prod_w_lp'(a_el[l]) * prod_w_lp'(b_el[l]);
            chunk_sum = chunk_sum + acc_width_p'(prod[l]);
            // AXPY reuses b as the addend; VMAC adds c
            if (op_q == op_axpy)
                r_n[(32'(cnt_q) * lanes_p + 32'(l)) * vdw_p +: vdw_p] =
                    vdw_p'(prod_w_lp'(s_q) * prod_w_lp'(a_el[l]) + prod_w_lp'(b_el[l]));
            else
                r_n[(32'(cnt_q) * lanes_p + 32'(l)) * vdw_p +: vdw_p] =
                    vdw_p'(prod[l] + prod_w_lp'(c_el[l]));
        end
    end

    // Operand latch, chunk counter and result/accumulator registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            acc_o    <= '0;
            r_data_o <= '0;
        end else if (accept) begin
            op_q  <= op_i;
            a_q   <= a_i;
            b_q   <= b_i;
            c_q   <= c_i;
            s_q   <= scalar_i;
            cnt_q <= '0;
            if (op_i == op_dot) acc_o <= '0;
        end else if (state_q == BUSY) begin
            cnt_q <= (cnt_q == last_cnt_lp) ? '0 : cnt_q + cnt_w_lp'(1);
            // op_q[1] clear selects the dot-product family
            if (!op_q[1]) acc_o    <= acc_o + chunk_sum;
            else          r_data_o <= r_n;
        end
    end

endmodule

// File: tb/tb_vector_mac_engine.sv
// Self-checking bench for vector_mac_engine with default parameters.
// Directed scenarios followed by randomized commands against a behavioural model.
module tb_vector_mac_engine;

    localparam int unsigned VL = 4;
    localparam int unsigned VW = 4;
    localparam int unsigned LN = 2;
    localparam int unsigned AW = 2 * VW + 2;
    localparam int unsigned N  = VL / LN;
    localparam int unsigned VB = VL * VW;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [1:0]    op_i;
    logic [VB-1:0] a_i, b_i, c_i;
    logic [VW-1:0] scalar_i;
    logic          v_i;
    logic          ready_o;
    logic [VB-1:0] r_data_o;
    logic [AW-1:0] acc_o;
    logic          v_o;
    logic          yumi_i;

    vector_mac_engine dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .c_i      (c_i),
        .scalar_i (scalar_i),
        .v_i      (v_i),
        .ready_o  (ready_o),
        .r_data_o (r_data_o),
        .acc_o    (acc_o),
        .v_o      (v_o),
        .yumi_i   (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [AW-1:0] acc_m;
    logic [VB-1:0] r_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int el(input logic [VB-1:0] v, input int i);
        return int'(v[i*VW +: VW]);
    endfunction

    // Whole-vector reference: plain integer arithmetic with modular wrap
    task automatic model(input logic [1:0] op, input logic [VB-1:0] a, input logic [VB-1:0] b,
                         input logic [VB-1:0] c, input logic [VW-1:0] s);
        int sum;
        sum = 0;
        for (int i = 0; i < VL; i++) sum += el(a, i) * el(b, i);
        case (op)
            2'd0: acc_m = AW'(sum % (1 << AW));
            2'd1: acc_m = AW'((int'(acc_m) + sum) % (1 << AW));
            2'd2: for (int i = 0; i < VL; i++)
                      r_m[i*VW +: VW] = VW'((el(a, i) * el(b, i) + el(c, i)) % (1 << VW));
            default: for (int i = 0; i < VL; i++)
                      r_m[i*VW +: VW] = VW'((int'(s) * el(a, i) + el(b, i)) % (1 << VW));
        endcase
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [VB-1:0] a, input logic [VB-1:0] b,
                           input logic [VB-1:0] c, input logic [VW-1:0] s,
                           input int hold, input bit noise);
        int lat;
        @(negedge clk_i);
        check("ready_idle", 64'(ready_o), 64'(1));
        op_i = op; a_i = a; b_i = b; c_i = c; scalar_i = s; v_i = 1'b1;
        @(negedge clk_i);
        v_i = 1'b0;
        model(op, a, b, c, s);
        check("ready_after_accept", 64'(ready_o), 64'(0));
        lat = 0;
        while (!v_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
        check("latency", 64'(lat), 64'(N));
        check("acc", 64'(acc_o), 64'(acc_m));
        check("r_data", 64'(r_data_o), 64'(r_m));
        for (int k = 0; k < hold; k++) begin
            if (noise) begin
                v_i = 1'b1; op_i = 2'($urandom);
                a_i = VB'($urandom); b_i = VB'($urandom); c_i = VB'($urandom);
                scalar_i = VW'($urandom);
            end
            @(negedge clk_i);
            check("hold_v", 64'(v_o), 64'(1));
            check("hold_ready", 64'(ready_o), 64'(0));
            check("hold_acc", 64'(acc_o), 64'(acc_m));
            check("hold_r", 64'(r_data_o), 64'(r_m));
        end
        v_i = 1'b0;
        yumi_i = 1'b1;
        @(negedge clk_i);
        yumi_i = 1'b0;
        check("v_after_yumi", 64'(v_o), 64'(0));
        check("ready_after_yumi", 64'(ready_o), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; op_i = '0;
        a_i = '0; b_i = '0; c_i = '0; scalar_i = '0;
        acc_m = '0; r_m = '0;
        #1 reset_i = 1'b1;
        #10;
        check("rst_ready", 64'(ready_o), 64'(1));
        check("rst_v", 64'(v_o), 64'(0));
        check("rst_acc", 64'(acc_o), 64'(0));
        check("rst_r", 64'(r_data_o), 64'(0));
        @(negedge clk_i);
        reset_i = 1'b0;

        // DOT then two DOT_ACC
        run_cmd(2'd0, 16'h4321, 16'h1111, 16'h0, 4'd0, 0, 1'b0);
        check("dot_10", 64'(acc_o), 64'(10));
        run_cmd(2'd1, 16'h4321, 16'h1111, 16'h0, 4'd0, 0, 1'b0);
        check("dotacc_20", 64'(acc_o), 64'(20));
        run_cmd(2'd1, 16'h4321, 16'h1111, 16'h0, 4'd0, 0, 1'b0);
        check("dotacc_30", 64'(acc_o), 64'(30));

        // VMAC leaves the accumulator alone
        run_cmd(2'd2, 16'h4321, 16'h2222, 16'h1111, 4'd0, 0, 1'b0);
        check("vmac_r", 64'(r_data_o), 64'(16'h9753));
        check("vmac_acc_kept", 64'(acc_o), 64'(30));
        run_cmd(2'd1, 16'h4321, 16'h1111, 16'h0, 4'd0, 0, 1'b0);
        check("dotacc_after_vmac", 64'(acc_o), 64'(40));
        run_cmd(2'd0, 16'h4321, 16'h1111, 16'h0, 4'd0, 0, 1'b0);
        check("dot_fresh", 64'(acc_o), 64'(10));

        // AXPY with element wrap
        run_cmd(2'd3, 16'h4321, 16'h0, 16'hFFFF, 4'd5, 0, 1'b0);
        check("axpy_r", 64'(r_data_o), 64'(16'h4FA5));
        check("axpy_acc_kept", 64'(acc_o), 64'(10));

        // Backpressure with new commands offered in DONE
        run_cmd(2'd2, 16'h1234, 16'h5678, 16'h9ABC, 4'd0, 5, 1'b1);
        repeat (2) begin
            @(negedge clk_i);
            check("no_spurious_v", 64'(v_o), 64'(0));
        end

        // Largest dot product fits the accumulator
        run_cmd(2'd0, 16'hFFFF, 16'hFFFF, 16'h0, 4'd0, 0, 1'b0);
        check("dot_900", 64'(acc_o), 64'(900));

        // Asynchronous reset in the middle of BUSY
        @(negedge clk_i);
        op_i = 2'd2; a_i = 16'h7777; b_i = 16'h3333; c_i = 16'h1111; v_i = 1'b1;
        @(posedge clk_i);
        #3 reset_i = 1'b1;
        #1;
        v_i = 1'b0;
        acc_m = '0; r_m = '0;
        check("midrst_v", 64'(v_o), 64'(0));
        check("midrst_ready", 64'(ready_o), 64'(1));
        check("midrst_acc", 64'(acc_o), 64'(0));
        check("midrst_r", 64'(r_data_o), 64'(0));
        @(negedge clk_i);
        reset_i = 1'b0;
        run_cmd(2'd1, 16'h4321, 16'h1111, 16'h0, 4'd0, 0, 1'b0);
        check("dotacc_after_rst", 64'(acc_o), 64'(10));

        // Randomized commands with random consumer delay
        for (int n = 0; n < 1000; n++) begin
            run_cmd(2'($urandom_range(0, 3)), VB'($urandom), VB'($urandom), VB'($urandom),
                    VW'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
